// File: rtl/rgu_spi_pkg.sv
// Shared types and defaults for the RGU SPI master: FSM state encoding,
// default parameters, command layout and the transfer-length clamp helper.
package rgu_spi_pkg;

  localparam int RGU_SPI_CLK_DIV_DEFAULT  = 2;
  localparam int RGU_SPI_MAX_BITS_DEFAULT = 32;
  localparam int RGU_SPI_LEN_W_DEFAULT    = $clog2(RGU_SPI_MAX_BITS_DEFAULT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } rgu_spi_state_e;

  // Command layout at the default widths.
  typedef struct packed {
    logic [2:0]                          cs;
    logic [RGU_SPI_LEN_W_DEFAULT-1:0]    len;
    logic [RGU_SPI_MAX_BITS_DEFAULT-1:0] data;
  } rgu_spi_cmd_t;

  function automatic int rgu_spi_clamp_len(input int len, input int max_bits);
    return (len > max_bits) ? max_bits : len;
  endfunction

endpackage

// File: rtl/rgu_spi_clkgen.sv
// Half-period tick generator for the SPI serial clock.
// Counts CLK_DIV cycles while enabled and holds at zero while disabled.
module rgu_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic half_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    half_tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d     = cnt_q;
    if (!en || half_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgu_spi_master.sv
// Mode-0 SPI master with eight active-low chip selects and a valid/ready command port.
// Optional feature macro RGU_SPI_LOOPBACK_EN: receive path samples the internal mosi register.
module rgu_spi_master
  import rgu_spi_pkg::*;
#(
  parameter int CLK_DIV  = RGU_SPI_CLK_DIV_DEFAULT,
  parameter int MAX_BITS = RGU_SPI_MAX_BITS_DEFAULT,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_cs,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                busy,
  output logic                sclk,
  output logic [7:0]          cs_n,
  output logic                mosi,
  input  logic                miso
);

  rgu_spi_state_e state_q, state_d;

  logic [LEN_W-1:0]    n_q, n_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MAX_BITS-1:0] tx_q, tx_d;
  logic [MAX_BITS-1:0] rx_q, rx_d;
  logic [MAX_BITS-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                sclk_q, sclk_d;
  logic [7:0]          cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic                zero_len_q, zero_len_d;

  logic                half_tick;
  logic                clk_en;
  logic                sample_bit;
  logic [LEN_W-1:0]    cmd_n;
  logic [MAX_BITS-1:0] tx_aligned;

  assign clk_en = (state_q != IDLE);

  rgu_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (clk_en),
    .half_tick (half_tick)
  );

`ifdef RGU_SPI_LOOPBACK_EN
  assign sample_bit = mosi_q;
`else
  assign sample_bit = miso;
`endif

  // Left-align the transmit word so the first bit always sits in the MSB.
  always_comb begin
    cmd_n      = LEN_W'(rgu_spi_clamp_len(int'(cmd_len), MAX_BITS));
    tx_aligned = cmd_data << (LEN_W'(MAX_BITS) - cmd_n);
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    zero_len_d  = zero_len_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          n_d       = cmd_n;
          bit_cnt_d = '0;
          rx_d      = '0;
          if (cmd_n == '0) begin
            // Zero-length command: answer immediately without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            zero_len_d  = 1'b1;
            state_d     = GAP;
          end else begin
            cs_n_d     = ~(8'd1 << cmd_cs);
            mosi_d     = tx_aligned[MAX_BITS-1];
            tx_d       = tx_aligned << 1;
            zero_len_d = 1'b0;
            state_d    = SETUP;
          end
        end
      end

      SETUP: begin
        if (half_tick) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[MAX_BITS-2:0], sample_bit};
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (half_tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_cnt_q == n_q - LEN_W'(1)) begin
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              mosi_d    = tx_q[MAX_BITS-1];
              tx_d      = tx_q << 1;
              bit_cnt_d = bit_cnt_q + LEN_W'(1);
            end
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[MAX_BITS-2:0], sample_bit};
          end
        end
      end

      HOLD: begin
        if (half_tick) begin
          cs_n_d      = 8'hff;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          state_d     = GAP;
        end
      end

      GAP: begin
        if (half_tick || zero_len_q) begin
          zero_len_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 8'hff;
      mosi_q      <= 1'b0;
      zero_len_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      zero_len_q  <= zero_len_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_rgu_spi_master.sv
// Scoreboard bench for rgu_spi_master: directed commands against a mode-0 slave model,
// with bus timing, chip-select, mosi order and response checks.
module tb_rgu_spi_master;
  import rgu_spi_pkg::*;

  localparam int D  = 2;
  localparam int MB = 32;
  localparam int LW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_cs = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [MB-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [MB-1:0] rsp_data;
  logic          busy;
  logic          sclk;
  logic [7:0]    cs_n;
  logic          mosi;
  logic          miso;

  rgu_spi_master #(
    .CLK_DIV  (D),
    .MAX_BITS (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_cs    (cmd_cs),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [MB-1:0] exp_q[$];
  logic [MB-1:0] exp_word;

  int            acc_cyc = 0;
  int            rel;
  int            pulses, cs_first, cs_last, rsp_rel, ready_rel, rsp_count;
  int            cs_bad, bus_idle_bad;
  int            accepts_bad = 0;
  int            busy_bad = 0;
  int            idle_run = 0;
  int            last_gap = -1;
  bit            had_active = 1'b0;
  logic [MB-1:0] mosi_cap;
  logic [7:0]    exp_cs_n = 8'hff;
  logic          prev_sclk = 1'b0;
  logic          prev_ready = 1'b0;

  int            sl_len = 0;
  int            sl_idx = -1;
  logic [MB-1:0] sl_word = '0;
  logic          sl_prev_sclk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Mode-0 slave: presents its MSB while selected and advances after each sclk fall.
  always @(negedge clk) begin : slave_model
    if (cs_n == 8'hff) begin
      sl_idx = sl_len - 1;
    end else if (sl_prev_sclk && !sclk) begin
      sl_idx--;
    end
    sl_prev_sclk = sclk;
    miso = (sl_idx >= 0 && sl_idx < MB) ? sl_word[sl_idx] : 1'b0;
  end

  // Monitor: pops the scoreboard on every response and gathers bus statistics.
  always @(negedge clk) begin : monitor
    rel = cyc - acc_cyc;
    if (rsp_valid) begin
      rsp_rel = rel;
      rsp_count++;
      if (exp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 1, 0);
      end else begin
        exp_word = exp_q.pop_front();
        checkOutput("rsp_data", rsp_data, exp_word);
      end
    end
    if (cs_n != 8'hff) begin
      if (cs_first < 0) cs_first = rel;
      cs_last = rel;
      if (cs_n != exp_cs_n) cs_bad++;
      if (had_active && idle_run > 0) last_gap = idle_run;
      had_active = 1'b1;
      idle_run   = 0;
    end else begin
      idle_run++;
      if (mosi !== 1'b0 || sclk !== 1'b0) bus_idle_bad++;
    end
    if (sclk && !prev_sclk) begin
      pulses++;
      mosi_cap = {mosi_cap[MB-2:0], mosi};
    end
    if (cmd_ready && !prev_ready) ready_rel = rel;
    if (busy == cmd_ready) busy_bad++;
    prev_sclk  = sclk;
    prev_ready = cmd_ready;
    if (cmd_valid && cmd_ready) begin
      acc_cyc = cyc;
      if (cs_n != 8'hff || sclk) accepts_bad++;
    end
  end

  task automatic clearStats();
    pulses       = 0;
    cs_first     = -1;
    cs_last      = -1;
    rsp_rel      = -1;
    ready_rel    = -1;
    rsp_count    = 0;
    cs_bad       = 0;
    bus_idle_bad = 0;
    mosi_cap     = '0;
  endtask

  task automatic applyStimulus(input rgu_spi_cmd_t cmd);
    int budget = 500;
    @(posedge clk);
    #1;
    cmd_cs    = cmd.cs;
    cmd_len   = cmd.len;
    cmd_data  = cmd.data;
    cmd_valid = 1'b1;
    while (!cmd_ready && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput("accept_timeout", longint'(budget == 0), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MB-1:0] lowMask(input int n);
    logic [MB-1:0] one = MB'(1);
    return (n >= MB) ? '1 : ((one << n) - one);
  endfunction

  function automatic logic [MB-1:0] expectedRsp(input int n, input logic [MB-1:0] data,
                                                input logic [MB-1:0] slave);
`ifdef RGU_SPI_LOOPBACK_EN
    return data & lowMask(n);
`else
    return slave & lowMask(n);
`endif
  endfunction

  task automatic waitReady(input string name);
    int budget = 500;
    while (ready_rel < 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput(name, longint'(budget == 0), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic runXfer(input logic [2:0] cs, input int len, input logic [MB-1:0] data,
                         input logic [MB-1:0] slave);
    rgu_spi_cmd_t cmd;
    int n = (len > MB) ? MB : len;
    cmd.cs   = cs;
    cmd.len  = LW'(len);
    cmd.data = data;
    sl_word  = slave;
    sl_len   = n;
    exp_cs_n = ~(8'd1 << cs);
    clearStats();
    exp_q.push_back(expectedRsp(n, data, slave));
    applyStimulus(cmd);
    cmd_valid = 1'b0;
    waitReady("done_timeout");
    checkOutput("sclk_pulses", pulses, n);
    checkOutput("mosi_bits", mosi_cap, data & lowMask(n));
    checkOutput("cs_first", cs_first, (n > 0) ? 1 : -1);
    checkOutput("cs_last", cs_last, (n > 0) ? 2 * n * D + D : -1);
    checkOutput("cs_value", cs_bad, 0);
    checkOutput("rsp_cycle", rsp_rel, (n > 0) ? 1 + (2 * n + 1) * D : 1);
    checkOutput("ready_cycle", ready_rel, (n > 0) ? 1 + (2 * n + 2) * D : 2);
    checkOutput("rsp_count", rsp_count, 1);
    checkOutput("bus_idle", bus_idle_bad, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_sclk"}, sclk, 0);
    checkOutput({tag, "_cs_n"}, cs_n, 8'hff);
    checkOutput({tag, "_mosi"}, mosi, 0);
  endtask

  initial begin : watchdog
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    rgu_spi_cmd_t cmd_a, cmd_b;
    int budget;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] basic transfer cs=3 len=8");
    runXfer(3'd3, 8, 32'h0000_00A5, 32'h0000_003C);

    $display("[TB] zero-length command");
    runXfer(3'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("[TB] over-length command clamps to MAX_BITS");
    runXfer(3'd6, 40, 32'hDEAD_BEEF, 32'h1234_5678);

    $display("[TB] back-to-back commands with cmd_valid held");
    clearStats();
    last_gap  = -1;
    sl_word   = 32'h6;
    sl_len    = 4;
    exp_cs_n  = 8'hff;
    cmd_a.cs  = 3'd1;
    cmd_a.len = LW'(4);
    cmd_a.data = 32'h9;
    cmd_b.cs  = 3'd7;
    cmd_b.len = LW'(4);
    cmd_b.data = 32'h3;
    exp_q.push_back(expectedRsp(4, cmd_a.data, 32'h6));
    exp_q.push_back(expectedRsp(4, cmd_b.data, 32'h6));
    applyStimulus(cmd_a);
    applyStimulus(cmd_b);
    cmd_valid = 1'b0;
    budget = 500;
    while (rsp_count < 2 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput("b2b_timeout", longint'(budget == 0), 0);
    checkOutput("b2b_gap", last_gap, D + 1);
    checkOutput("b2b_pulses", pulses, 8);
    checkOutput("b2b_mosi", mosi_cap, 32'h93);
    ready_rel = -1;
    waitReady("b2b_ready_timeout");

    $display("[TB] reset during transfer");
    clearStats();
    sl_word  = 32'hC3;
    sl_len   = 8;
    exp_cs_n = ~(8'd1 << 4);
    cmd_a.cs   = 3'd4;
    cmd_a.len  = LW'(8);
    cmd_a.data = 32'h5A;
    exp_q.push_back(expectedRsp(8, cmd_a.data, sl_word));
    applyStimulus(cmd_a);
    cmd_valid = 1'b0;
    budget = 500;
    while (pulses < 3 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput("rise3_timeout", longint'(budget == 0), 0);
    checkOutput("pre_reset_sclk", sclk, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * D + 4) @(posedge clk);
    #1;
    checkOutput("midreset_no_rsp", rsp_count, 0);

    $display("[TB] transfer after reset");
    runXfer(3'd0, 8, 32'h0000_0081, 32'h0000_007E);

    $display("[TB] 16-bit transfer with miso held low");
    runXfer(3'd5, 16, 32'h0000_BEEF, 32'h0000_0000);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("accept_only_idle", accepts_bad, 0);
    checkOutput("busy_vs_ready", busy_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgu_spi_master.md
# rgu_spi_master

SPI master controller for the RGU SPI bus. Accepts transfer commands over a valid/ready interface and selects one of eight active-low chip selects. Generates a mode-0 serial clock, shifts `mosi` MSB-first, captures `miso` and returns the received word on a one-cycle response strobe. It drives the same `clk`-domain bus (`cs[7:0]`, `sclk`, `mosi`, `miso`) that the RGU agent monitor observes, with idle bus = `cs_n == 8'hff`.

## Interface
Parameters:
- `CLK_DIV`, 2: `clk` cycles per `sclk` half-period; legal range ≥1.
- `MAX_BITS`, 32: maximum bits per transfer and width of the data buses.
- `LEN_W`, `$clog2(MAX_BITS+1)`: width of the length field.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`.
- `cmd_cs` in 3: chip-select index 0..7.
- `cmd_len` in LEN_W: number of bits to transfer.
- `cmd_data` in MAX_BITS: transmit word, right-aligned.
- `rsp_valid` out 1: one-cycle pulse when a transfer completes; no backpressure.
- `rsp_data` out MAX_BITS: received word, right-aligned, upper bits zero.
- `busy` out 1: high from the cycle after accept until the cycle `cmd_ready` returns high.
- `sclk` out 1: serial clock; idles low.
- `cs_n` out 8: one-hot-low chip selects; `8'hff` when idle.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in; sampled only on `sclk` rising edges.

## Operation
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `sclk`=0, `cs_n`=8'hff, `mosi`=0.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- Accept: latch the command. `n = min(cmd_len, MAX_BITS)`. Transmit order is `cmd_data[n-1]` down to bit 0.
- SETUP: `cs_n[cmd_cs]` goes low and `mosi` presents the first bit. Duration is CLK_DIV cycles.
- SHIFT:
  - `sclk` toggles every CLK_DIV cycles.
  - On each rise, `miso` shifts into the receive register LSB.
  - On each fall except the last, `mosi` advances to the next bit.
  - The state is left after the n-th fall.
- HOLD: `sclk` stays low and `cs_n` stays asserted for CLK_DIV cycles. On exit, `cs_n` returns to 8'hff and, in the same cycle, `rsp_valid` pulses with `rsp_data` holding the n received bits.
- GAP: all chip selects are high for CLK_DIV cycles, which guarantees a visible deselect between back-to-back transfers. Then return to IDLE.
- `cmd_len` = 0: command is accepted and no bus activity occurs. `rsp_valid` pulses on the cycle after accept with `rsp_data`=0, and `cmd_ready` returns high the cycle after that.
- `cmd_len` > MAX_BITS: clamped to MAX_BITS.
- `rsp_data` holds its value until the next completion. `mosi` is driven to 0 outside SETUP and SHIFT.
- Reset mid-transfer: all outputs immediately take their reset values and no response is produced.

## Timing
- Accept at cycle 0. With D = CLK_DIV:
  - `cs_n` asserts at cycle 1.
  - The k-th rise is at 1+(2k−1)D and the k-th fall at 1+2kD.
  - `cs_n` deasserts and `rsp_valid` pulses at 1+(2n+1)D.
  - `cmd_ready` rises at 1+(2n+2)D.
- `cmd_valid` must hold, with stable fields, until accepted. Fields are ignored when `cmd_ready` is low.
- `sclk`, `cs_n` and `mosi` are registered outputs with no combinational path from inputs.

## Configuration
- `RGU_SPI_LOOPBACK_EN` defined: the receive path samples the internal `mosi` register instead of the `miso` pin, so `rsp_data` equals the low n bits of `cmd_data`. Pins are still driven normally.
- Undefined: `miso` is sampled as above and no loopback logic exists.

## Structure
- Package `rgu_spi_pkg` contains:
  - the state enum `rgu_spi_state_e` (IDLE, SETUP, SHIFT, HOLD, GAP);
  - the default constants for CLK_DIV and MAX_BITS;
  - the `rgu_spi_cmd_t` struct (cs, len, data).
- Sub-module `rgu_spi_clkgen`: divide counter enabled during SETUP, SHIFT, HOLD and GAP. It emits a `half_tick` every CLK_DIV cycles and reloads when disabled.

## Test plan
- D=2, cs=3, len=8, data=8'hA5, `miso` tied to a slave returning 8'h3C:
  - `cs_n`=8'hf7 from cycle 1 to 34;
  - 8 `sclk` pulses;
  - `mosi` sequence 1,0,1,0,0,1,0,1;
  - `rsp_valid` at cycle 35 with `rsp_data`=32'h3C;
  - `cmd_ready` at 37.
- Back-to-back commands with `cmd_valid` held high: at least D cycles of `cs_n`=8'hff between transfers, and each accept occurs only in IDLE.
- len=0: `rsp_valid` at cycle 1 with `rsp_data`=0, and `cs_n` and `sclk` never toggle.
- len=40 with MAX_BITS=32: exactly 32 `sclk` pulses and the full 32-bit response.
- `rst_n` asserted after the 3rd rise: outputs take reset values asynchronously, no `rsp_valid`, and the next command runs correctly.
- `RGU_SPI_LOOPBACK_EN` with `miso` held 0, len=16, data=16'hBEEF: `rsp_data`=32'hBEEF.
